// File: rtl/producer_mc.sv
// ---------------------------------------------------------------------------
// producer_mc
//   Multi-channel write-side producer for an async FIFO write domain.
//   Each of NUM_CH request sources stages words in a private BUF_DEPTH-deep
//   buffer. A round-robin arbiter drains one word per cycle into a single
//   registered FIFO write port, gated by the FIFO's f_full backpressure.
//   Words offered to a full buffer are dropped, and a sticky per-channel
//   overflow flag records the drop.
//
// Ports
//   w_clk    in   write-domain clock
//   wrst     in   synchronous active-high reset
//   wr_req   in   per-channel write request (one word per cycle)
//   data_in  in   channel i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_rdy   out  channel i buffer can accept a word this cycle
//   f_full   in   FIFO full / almost-full backpressure
//   d_out    out  registered data to the FIFO write port
//   w_en     out  registered FIFO write enable
//   w_ch     out  source channel of the current d_out
//   ovf      out  sticky: channel i dropped a word
// ---------------------------------------------------------------------------
module producer_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                         w_clk,
  input  logic                         wrst,
  input  logic [NUM_CH-1:0]            wr_req,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]            wr_rdy,
  input  logic                         f_full,
  output logic [DATA_WIDTH-1:0]        d_out,
  output logic                         w_en,
  output logic [$clog2(NUM_CH)-1:0]    w_ch,
  output logic [NUM_CH-1:0]            ovf
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int PTR_W = CNT_W - 1;

  // Per-channel staging storage and bookkeeping
  logic [DATA_WIDTH-1:0] r_buf    [NUM_CH][BUF_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr [NUM_CH];
  logic [PTR_W-1:0]      r_rd_ptr [NUM_CH];
  logic [CNT_W-1:0]      r_cnt    [NUM_CH];

  // Arbiter state and registered write port
  logic [CH_W-1:0]       r_last;
  logic [NUM_CH-1:0]     r_ovf;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_dout;
  logic [CH_W-1:0]       r_ch;

  logic [NUM_CH-1:0]     w_rdy;
  logic [NUM_CH-1:0]     w_push;
  logic [NUM_CH-1:0]     w_elig;
  logic [NUM_CH-1:0]     w_pop_ch;
  logic                  w_gnt_vld;
  logic [CH_W-1:0]       w_gnt;
  logic                  w_pop;

  // Acceptance depends only on the count at cycle start, so a pop on the
  // same edge never frees a slot for a push in that cycle.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_rdy[i]  = (r_cnt[i] < CNT_W'(BUF_DEPTH));
      w_push[i] = wr_req[i] & w_rdy[i];
      w_elig[i] = (r_cnt[i] != '0);
    end
  end

  // Round-robin scan starting just after the last grant. The loop walks
  // offsets from farthest to nearest so the final assignment is the
  // nearest eligible channel, giving priority without an early exit.
  always_comb begin
    int v_idx;
    v_idx     = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      v_idx = (int'(r_last) + off) % NUM_CH;
      if (w_elig[v_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = CH_W'(v_idx);
      end
    end
  end

  assign w_pop = w_gnt_vld & ~f_full;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop_ch[i] = w_pop && (int'(w_gnt) == i);
    end
  end

  // Stage p0: buffer write. Storage is not reset; emptiness is tracked
  // entirely by r_cnt, so stale contents are never observed.
  always_ff @(posedge w_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!wrst && w_push[i]) begin
        r_buf[i][r_wr_ptr[i]] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Stage p0: pointers, counts and sticky overflow flags
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i]) begin
          r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        end
        if (w_pop_ch[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        end
        case ({w_push[i], w_pop_ch[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
          default: r_cnt[i] <= r_cnt[i];
        endcase
        if (wr_req[i] && !w_rdy[i]) begin
          r_ovf[i] <= 1'b1;
        end
      end
    end
  end

  // Stage p1: registered FIFO write port. d_out, w_ch and the round-robin
  // pointer hold their values whenever no word is issued.
  always_ff @(posedge w_clk) begin
    if (wrst) begin
      r_wen  <= 1'b0;
      r_dout <= '0;
      r_ch   <= '0;
      r_last <= CH_W'(NUM_CH - 1);
    end else begin
      r_wen <= w_pop;
      if (w_pop) begin
        r_dout <= r_buf[w_gnt][r_rd_ptr[w_gnt]];
        r_ch   <= w_gnt;
        r_last <= w_gnt;
      end
    end
  end

  assign wr_rdy = w_rdy;
  assign d_out  = r_dout;
  assign w_en   = r_wen;
  assign w_ch   = r_ch;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_producer_mc.sv
// ---------------------------------------------------------------------------
// tb_producer_mc
//   Self-checking bench for producer_mc. A queue-per-channel reference model
//   tracks buffered words, the round-robin pointer and the sticky drop flags;
//   every cycle the DUT's wr_rdy and write-port outputs are compared to it.
// ---------------------------------------------------------------------------
module tb_producer_mc;

  localparam int DW     = 32;
  localparam int NUM_CH = 4;
  localparam int BD     = 2;
  localparam int CH_W   = $clog2(NUM_CH);

  logic                     w_clk;
  logic                     wrst;
  logic [NUM_CH-1:0]        wr_req;
  logic [NUM_CH*DW-1:0]     data_in;
  logic [NUM_CH-1:0]        wr_rdy;
  logic                     f_full;
  logic [DW-1:0]            d_out;
  logic                     w_en;
  logic [CH_W-1:0]          w_ch;
  logic [NUM_CH-1:0]        ovf;

  producer_mc #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NUM_CH),
    .BUF_DEPTH  (BD)
  ) dut (
    .w_clk   (w_clk),
    .wrst    (wrst),
    .wr_req  (wr_req),
    .data_in (data_in),
    .wr_rdy  (wr_rdy),
    .f_full  (f_full),
    .d_out   (d_out),
    .w_en    (w_en),
    .w_ch    (w_ch),
    .ovf     (ovf)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0]     m_q [NUM_CH][$];
  int                m_last;
  logic              m_wen;
  logic [DW-1:0]     m_dout;
  int                m_ch;
  logic [NUM_CH-1:0] m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH-1:0] m_rdy();
    logic [NUM_CH-1:0] r;
    for (int i = 0; i < NUM_CH; i++) r[i] = (m_q[i].size() < BD);
    return r;
  endfunction

  function automatic logic [NUM_CH*DW-1:0] rnd_din();
    logic [NUM_CH*DW-1:0] d;
    for (int i = 0; i < NUM_CH; i++) d[i*DW +: DW] = $urandom;
    return d;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NUM_CH; i++) m_q[i].delete();
    m_last = NUM_CH - 1;
    m_wen  = 1'b0;
    m_dout = '0;
    m_ch   = 0;
    m_ovf  = '0;
  endtask

  // One clock cycle: apply inputs, check readiness, advance model, check port.
  task automatic step(input logic rst, input logic [NUM_CH-1:0] req,
                      input logic ff, input logic [NUM_CH*DW-1:0] din);
    logic [NUM_CH-1:0] rdy;
    wrst    = rst;
    wr_req  = req;
    f_full  = ff;
    data_in = din;
    rdy     = m_rdy();
    #1;
    check("wr_rdy", 32'(wr_rdy), 32'(rdy));
    @(posedge w_clk);
    if (rst) begin
      m_reset();
    end else begin
      m_wen = 1'b0;
      if (!ff) begin
        for (int off = 1; off <= NUM_CH && !m_wen; off++) begin
          int c;
          c = (m_last + off) % NUM_CH;
          if (m_q[c].size() != 0) begin
            m_dout = m_q[c].pop_front();
            m_ch   = c;
            m_last = c;
            m_wen  = 1'b1;
          end
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (req[i]) begin
          if (rdy[i]) m_q[i].push_back(din[i*DW +: DW]);
          else        m_ovf[i] = 1'b1;
        end
      end
    end
    #1;
    check("w_en",  32'(w_en),  32'(m_wen));
    check("d_out", d_out,      m_dout);
    check("w_ch",  32'(w_ch),  32'(m_ch));
    check("ovf",   32'(ovf),   32'(m_ovf));
  endtask

  initial begin
    logic [NUM_CH*DW-1:0] d;
    wrst    = 1'b1;
    wr_req  = '0;
    f_full  = 1'b0;
    data_in = '0;
    m_reset();
    repeat (2) @(posedge w_clk);
    #1;
    check("rst_w_en", 32'(w_en), 32'd0);
    check("rst_d_out", d_out, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_rdy", 32'(wr_rdy), 32'hF);

    // Single word on channel 1: visible on the port after the second edge
    step(1'b0, '0, 1'b0, '0);
    d = '0;
    d[1*DW +: DW] = 32'hA5A5_0001;
    step(1'b0, 4'b0010, 1'b0, d);
    check("t1_wen_early", 32'(w_en), 32'd0);
    step(1'b0, '0, 1'b0, '0);
    check("t1_wen", 32'(w_en), 32'd1);
    check("t1_dout", d_out, 32'hA5A5_0001);
    check("t1_ch", 32'(w_ch), 32'd1);
    step(1'b0, '0, 1'b0, '0);
    check("t1_wen_after", 32'(w_en), 32'd0);

    // All channels requesting whenever ready, no backpressure
    step(1'b1, '0, 1'b0, '0);
    for (int k = 0; k < 12; k++) step(1'b0, m_rdy(), 1'b0, rnd_din());
    check("t2_ovf", 32'(ovf), 32'd0);
    check("t2_wen", 32'(w_en), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, '0);

    // Backpressure: third push on channel 0 is dropped
    step(1'b1, '0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      d = '0;
      d[DW-1:0] = 32'h10 + k;
      step(1'b0, 4'b0001, 1'b1, d);
    end
    check("t3_ovf0", 32'(ovf[0]), 32'd1);
    check("t3_rdy0", 32'(wr_rdy[0]), 32'd0);
    step(1'b0, '0, 1'b0, '0);
    check("t3_first", d_out, 32'h10);
    step(1'b0, '0, 1'b0, '0);
    check("t3_second", d_out, 32'h11);
    step(1'b0, '0, 1'b0, '0);
    check("t3_ovf_sticky", 32'(ovf[0]), 32'd1);

    // Channel 2 full, pop and push attempt on the same edge
    step(1'b1, '0, 1'b0, '0);
    step(1'b0, 4'b0100, 1'b1, rnd_din());
    step(1'b0, 4'b0100, 1'b1, rnd_din());
    step(1'b0, 4'b0100, 1'b0, rnd_din());
    step(1'b0, '0, 1'b0, '0);
    check("t4_rdy2", 32'(wr_rdy[2]), 32'd1);
    for (int k = 0; k < 2; k++) step(1'b0, '0, 1'b0, '0);

    // Reset in the middle of traffic with several buffers occupied
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0111 & m_rdy(), 1'b1, rnd_din());
    step(1'b1, 4'b0111, 1'b1, rnd_din());
    check("t5_wen", 32'(w_en), 32'd0);
    check("t5_ovf", 32'(ovf), 32'd0);
    step(1'b0, 4'b1010, 1'b0, rnd_din());
    check("t5_rdy", 32'(wr_rdy), 32'hF);
    step(1'b0, '0, 1'b0, '0);
    check("t5_first_ch", 32'(w_ch), 32'd1);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b0, '0);

    // Only channels 0 and 3 active: grants alternate starting with 0
    step(1'b1, '0, 1'b0, '0);
    for (int k = 0; k < 10; k++) step(1'b0, 4'b1001 & m_rdy(), 1'b0, rnd_din());
    for (int k = 0; k < 4; k++) step(1'b0, '0, 1'b0, '0);

    // Randomized traffic with backpressure, drops and occasional resets
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 63) == 0), NUM_CH'($urandom),
           ($urandom_range(0, 3) == 0), rnd_din());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
